// File: rtl/instr_sequencer.sv
// Instruction sequencer: loadable program store with PC, branch targets
// and halt/wrap at a programmed last address. Feeds the core's instr port.
module instr_sequencer #(
    parameter int INSTR_W = 6,
    parameter int ADDR_W  = 4,
    parameter int WRAP    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_tgt,
    input  logic [ADDR_W-1:0]  last_addr,
    input  logic               run,
    input  logic               cjump,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               running,
    output logic               halted
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;

    logic [INSTR_W-1:0] word_mem [DEPTH];
    logic [ADDR_W-1:0]  tgt_mem  [DEPTH];

    logic               we;
    logic [ADDR_W-1:0]  jump_tgt;
    logic [ADDR_W-1:0]  next_addr;
    logic [INSTR_W-1:0] next_word;

    // Loads are only accepted while idle, so a running program is stable.
    assign we = load_en && (state == IDLE);

    // Pick the next fetch address and read it with write-first bypass.
    always_comb begin
        jump_tgt  = tgt_mem[pc];
        next_addr = pc + 1'b1;
        next_word = '0;
        if (we && (load_addr == pc)) begin
            jump_tgt = load_tgt;
        end
        if (state != RUN) begin
            next_addr = '0;
        end else if (cjump) begin
            next_addr = jump_tgt;
        end else if (pc == last_addr) begin
            next_addr = '0;
        end
        if (we && (load_addr == next_addr)) begin
            next_word = load_instr;
        end else begin
            next_word = word_mem[next_addr];
        end
    end

    // Program store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            word_mem[load_addr] <= load_instr;
            tgt_mem[load_addr]  <= load_tgt;
        end
    end

    // Sequencer FSM with registered instruction, PC and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            instr   <= '0;
            running <= 1'b0;
            halted  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state   <= RUN;
                        pc      <= '0;
                        instr   <= next_word;
                        running <= 1'b1;
                    end else begin
                        instr <= '0;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state   <= IDLE;
                        instr   <= '0;
                        running <= 1'b0;
                    end else if (cjump) begin
                        pc    <= next_addr;
                        instr <= next_word;
                    end else if (pc == last_addr) begin
                        if (WRAP != 0) begin
                            pc    <= next_addr;
                            instr <= next_word;
                        end else begin
                            state   <= HALT;
                            instr   <= '0;
                            running <= 1'b0;
                            halted  <= 1'b1;
                        end
                    end else begin
                        pc    <= next_addr;
                        instr <= next_word;
                    end
                end
                HALT: begin
                    instr <= '0;
                    if (!run) begin
                        state  <= IDLE;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    instr   <= '0;
                    running <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected {instr,pc,running,halted}
// is queued per cycle by the stimulus and checked by a separate monitor.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic [3:0] load_addr;
    logic [5:0] load_instr;
    logic [3:0] load_tgt;
    logic [3:0] last_addr;
    logic       run;
    logic       run_w;
    logic       cjump;
    logic       ld_w_en;

    logic [5:0] instr,   instr_w;
    logic [3:0] pc,      pc_w;
    logic       running, running_w;
    logic       halted,  halted_w;

    logic [11:0] q0[$];
    logic [11:0] qw[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.INSTR_W(6), .ADDR_W(4), .WRAP(0)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_instr(load_instr), .load_tgt(load_tgt),
        .last_addr(last_addr), .run(run), .cjump(cjump),
        .instr(instr), .pc(pc), .running(running), .halted(halted)
    );

    instr_sequencer #(.INSTR_W(6), .ADDR_W(4), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .load_en(load_en & ld_w_en),
        .load_addr(load_addr), .load_instr(load_instr),
        .load_tgt(load_tgt), .last_addr(last_addr), .run(run_w),
        .cjump(cjump), .instr(instr_w), .pc(pc_w),
        .running(running_w), .halted(halted_w)
    );

    function automatic logic [11:0] e(input logic [5:0] i, input logic [3:0] p,
                                      input logic r, input logic h);
        return {i, p, r, h};
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s#%0d: got instr=%h pc=%0d run=%b halt=%b, want instr=%h pc=%0d run=%b halt=%b",
                     nm, idx, act[11:6], act[5:2], act[1], act[0],
                     exp[11:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: check each DUT shortly after every rising edge.
    initial begin
        int k0 = 0;
        int kw = 0;
        logic [11:0] x;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                x = q0.pop_front();
                chk("dut", k0, {instr, pc, running, halted}, x);
                k0++;
            end
            if (qw.size() > 0) begin
                x = qw.pop_front();
                chk("dut_w", kw, {instr_w, pc_w, running_w, halted_w}, x);
                kw++;
            end
        end
    end

    task automatic step(input logic [11:0] x);
        q0.push_back(x);
        @(negedge clk);
    endtask

    task automatic step2(input logic [11:0] x, input logic [11:0] xw);
        q0.push_back(x);
        qw.push_back(xw);
        @(negedge clk);
    endtask

    task automatic ld(input logic [3:0] a, input logic [5:0] w,
                      input logic [3:0] t);
        load_en    = 1'b1;
        load_addr  = a;
        load_instr = w;
        load_tgt   = t;
        step(e(6'h00, 4'd0, 1'b0, 1'b0));
        load_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_instr = '0;
        load_tgt = '0; last_addr = 4'd3; run = 1'b0; run_w = 1'b0;
        cjump = 1'b0; ld_w_en = 1'b1;
        @(negedge clk);

        // Reset then idle
        repeat (2) step(e(6'h00, 4'd0, 1'b0, 1'b0));
        rst = 1'b0;
        repeat (5) step(e(6'h00, 4'd0, 1'b0, 1'b0));

        // Program: word/tgt pairs
        ld(4'd0, 6'h11, 4'd0);
        ld(4'd1, 6'h12, 4'd0);
        ld(4'd2, 6'h13, 4'd0);
        ld(4'd3, 6'h14, 4'd1);
        ld(4'd4, 6'h15, 4'd0);
        ld(4'd5, 6'h16, 4'd0);
        ld_w_en = 1'b0;

        // Linear run to halt
        run = 1'b1;
        step(e(6'h11, 4'd0, 1'b1, 1'b0));
        step(e(6'h12, 4'd1, 1'b1, 1'b0));
        step(e(6'h13, 4'd2, 1'b1, 1'b0));
        step(e(6'h14, 4'd3, 1'b1, 1'b0));
        step(e(6'h00, 4'd3, 1'b0, 1'b1));
        step(e(6'h00, 4'd3, 1'b0, 1'b1));
        run = 1'b0;
        step(e(6'h00, 4'd3, 1'b0, 1'b0));
        step(e(6'h00, 4'd3, 1'b0, 1'b0));

        // Branch taken at pc 2, then sequential to last=5
        last_addr = 4'd5;
        run = 1'b1;
        step(e(6'h11, 4'd0, 1'b1, 1'b0));
        step(e(6'h12, 4'd1, 1'b1, 1'b0));
        step(e(6'h13, 4'd2, 1'b1, 1'b0));
        cjump = 1'b1;
        step(e(6'h11, 4'd0, 1'b1, 1'b0));
        cjump = 1'b0;
        step(e(6'h12, 4'd1, 1'b1, 1'b0));
        step(e(6'h13, 4'd2, 1'b1, 1'b0));
        step(e(6'h14, 4'd3, 1'b1, 1'b0));
        step(e(6'h15, 4'd4, 1'b1, 1'b0));
        step(e(6'h16, 4'd5, 1'b1, 1'b0));
        step(e(6'h00, 4'd5, 1'b0, 1'b1));
        run = 1'b0;
        step(e(6'h00, 4'd5, 1'b0, 1'b0));

        // Jump at last address beats halt; cjump ignored in HALT
        last_addr = 4'd3;
        run = 1'b1;
        step(e(6'h11, 4'd0, 1'b1, 1'b0));
        step(e(6'h12, 4'd1, 1'b1, 1'b0));
        step(e(6'h13, 4'd2, 1'b1, 1'b0));
        step(e(6'h14, 4'd3, 1'b1, 1'b0));
        cjump = 1'b1;
        step(e(6'h12, 4'd1, 1'b1, 1'b0));
        cjump = 1'b0;
        step(e(6'h13, 4'd2, 1'b1, 1'b0));
        step(e(6'h14, 4'd3, 1'b1, 1'b0));
        step(e(6'h00, 4'd3, 1'b0, 1'b1));
        cjump = 1'b1;
        step(e(6'h00, 4'd3, 1'b0, 1'b1));
        cjump = 1'b0;
        run = 1'b0;
        step(e(6'h00, 4'd3, 1'b0, 1'b0));

        // Load lockout during RUN, then abort mid-program
        run = 1'b1;
        step(e(6'h11, 4'd0, 1'b1, 1'b0));
        load_en = 1'b1; load_addr = 4'd1; load_instr = 6'h3F; load_tgt = 4'd7;
        step(e(6'h12, 4'd1, 1'b1, 1'b0));
        load_en = 1'b0;
        step(e(6'h13, 4'd2, 1'b1, 1'b0));
        run = 1'b0;
        step(e(6'h00, 4'd2, 1'b0, 1'b0));
        step(e(6'h00, 4'd2, 1'b0, 1'b0));
        run = 1'b1;
        step(e(6'h11, 4'd0, 1'b1, 1'b0));
        step(e(6'h12, 4'd1, 1'b1, 1'b0));
        run = 1'b0;
        step(e(6'h00, 4'd1, 1'b0, 1'b0));

        // Write-first on start
        load_en = 1'b1; load_addr = 4'd0; load_instr = 6'h2A; load_tgt = 4'd0;
        run = 1'b1;
        step(e(6'h2A, 4'd0, 1'b1, 1'b0));
        load_en = 1'b0;
        step(e(6'h12, 4'd1, 1'b1, 1'b0));

        // Reset mid-RUN
        rst = 1'b1;
        step(e(6'h00, 4'd0, 1'b0, 1'b0));
        rst = 1'b0; run = 1'b0;
        step(e(6'h00, 4'd0, 1'b0, 1'b0));
        step(e(6'h00, 4'd0, 1'b0, 1'b0));

        // WRAP=1 instance: pc 3 -> 0 and keeps running
        run_w = 1'b1;
        step2(e(6'h00, 4'd0, 1'b0, 1'b0), e(6'h11, 4'd0, 1'b1, 1'b0));
        step2(e(6'h00, 4'd0, 1'b0, 1'b0), e(6'h12, 4'd1, 1'b1, 1'b0));
        step2(e(6'h00, 4'd0, 1'b0, 1'b0), e(6'h13, 4'd2, 1'b1, 1'b0));
        step2(e(6'h00, 4'd0, 1'b0, 1'b0), e(6'h14, 4'd3, 1'b1, 1'b0));
        step2(e(6'h00, 4'd0, 1'b0, 1'b0), e(6'h11, 4'd0, 1'b1, 1'b0));
        step2(e(6'h00, 4'd0, 1'b0, 1'b0), e(6'h12, 4'd1, 1'b1, 1'b0));
        run_w = 1'b0;
        step2(e(6'h00, 4'd0, 1'b0, 1'b0), e(6'h00, 4'd1, 1'b0, 1'b0));

        @(posedge clk);
        #2;
        n_cmp++;
        if (q0.size() + qw.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", q0.size() + qw.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction source for the `top` CPU core: the other end of its `instr` / `cjump` interface.
- Holds a small loadable program store and a program counter (PC).
- While running, presents one 6-bit instruction per clock on `instr`.
- Follows the core's `cjump` by loading a per-word branch target, otherwise steps sequentially; halts or wraps at a programmed last address.

Parameters:
- INSTR_W, 6, instruction width; must match the core's `instr` port.
- ADDR_W, 4, PC / store address width; DEPTH = 2**ADDR_W words.
- WRAP, 0, 1 = PC returns to 0 after `last_addr`; 0 = enter HALT.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  write strobe into program store; honoured in IDLE only.
- load_addr  in  ADDR_W  write address.
- load_instr  in  INSTR_W  instruction word to store.
- load_tgt  in  ADDR_W  branch target stored alongside the word.
- last_addr  in  ADDR_W  final address of the program; sampled every RUN cycle.
- run  in  1  level: 1 = start/continue execution, 0 = abort/return to IDLE.
- cjump  in  1  from core; 1 = branch taken for the instruction currently on `instr`.
- instr  out  INSTR_W  registered instruction to core; 0 (NOP) when not running.
- pc  out  ADDR_W  registered address of the word currently on `instr`.
- running  out  1  1 in RUN.
- halted  out  1  1 in HALT.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, pc=0, instr=0, running=0, halted=0.
  - Store contents are not cleared: undefined until loaded.
- Store:
  - DEPTH entries of {tgt[ADDR_W], word[INSTR_W]}.
  - Written at the edge when load_en=1 and state==IDLE; load_en ignored in RUN/HALT.
  - Reads are write-first: a fetch from the address being written in the same cycle returns the new data.
- Invariant: in RUN, instr == word[pc] for the contents at the time of fetch; instr and pc update on the same edge.
- States: IDLE, RUN, HALT.
- IDLE:
  - run=1 -> RUN; pc<=0; instr<=word[0]. First instruction is visible the cycle after run rises (latency 1).
  - Otherwise instr stays 0 and pc holds.
- RUN, evaluated each edge in this priority:
  1. run=0 -> IDLE; instr<=0; pc holds its value.
  2. cjump=1 -> pc<=tgt[pc]; instr<=word[tgt[pc]]. A jump wins even when pc==last_addr.
  3. pc==last_addr:
     - WRAP=1 -> pc<=0; instr<=word[0].
     - WRAP=0 -> HALT; instr<=0; pc holds.
  4. Otherwise pc<=pc+1 (mod DEPTH, natural wrap); instr<=word[pc+1].
- HALT: instr=0; run=0 -> IDLE; run held 1 stays in HALT. Restart requires run low for at least one cycle.
- cjump is ignored outside RUN.
- Outputs: running = (state==RUN); halted = (state==HALT); both registered with state.
- Reset mid-RUN: returns to IDLE with instr=0 on the next edge; no further instructions are issued.
- last_addr changed mid-run takes effect on the next comparison.
- A jump target beyond last_addr is legal; execution continues and halts/wraps only if pc later equals last_addr exactly.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, run=0 -> instr=0, pc=0, running=0, halted=0 for 5 cycles.
- Linear program (WRAP=0):
  - Stimulus: load words 0..3 = 6'h11, 6'h12, 6'h13, 6'h14 with last_addr=3; raise run.
  - Expected: instr = 11, 12, 13, 14 on cycles 1–4 with pc 0–3; then halted=1, instr=0. Lower run -> IDLE.
- Branch taken:
  - Stimulus: word2 has tgt=0, last_addr=5; assert cjump for one cycle while pc==2.
  - Expected: next cycle pc=0, instr=word[0]. Without cjump, pc=3.
- Jump vs last:
  - Stimulus: pc==last_addr==3 with cjump=1 and tgt[3]=1.
  - Expected: pc=1, no HALT.
  - Also build with WRAP=1, no cjump: pc 3 -> 0, running stays 1.
- Load lockout and abort:
  - Stimulus: load_en=1 to addr 1 with 6'h3F during RUN.
  - Expected: store unchanged (later fetch of addr 1 returns the old word).
  - Stimulus: run=0 mid-program.
  - Expected: next cycle instr=0, running=0, pc frozen.
- Write-first on start: in the same IDLE cycle, load addr 0 with 6'h2A and raise run -> first issued instr=6'h2A.
